// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a small
// elastic FIFO presented through valid/ready. Errors are reported as 1-cycle pulses.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 16000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CPB = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  generate
    if (CPB < 8) begin : g_cpb_chk
      $error("uart_rx_fifo: CLKS_PER_BIT must be >= 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  logic          rxd_m, rxd_s;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          push, ferr_n;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, wr_en, ovr_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= uart_rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push      = 1'b0;
    ferr_n    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxd_s) state_n = START;
      end
      START: if (cnt == HALF_LAST) begin
        cnt_n     = '0;
        bit_idx_n = '0;
        state_n   = rxd_s ? IDLE : DATA;
      end
      DATA: if (cnt == BIT_LAST) begin
        cnt_n     = '0;
        shreg_n   = {rxd_s, shreg[7:1]};
        bit_idx_n = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_n = STOP;
      end
      STOP: if (cnt == BIT_LAST) begin
        cnt_n   = '0;
        push    = rxd_s;
        ferr_n  = !rxd_s;
        state_n = rxd_s ? IDLE : BREAK;
      end
      BREAK: begin
        // Line held low: stay here so a long break yields a single error.
        cnt_n = '0;
        if (rxd_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign rx_valid   = (count != '0);
  assign full       = (count == FULL_CNT);
  assign pop        = rx_valid && rx_ready;
  // A full FIFO still accepts a byte when the head is popped on the same edge.
  assign wr_en      = push && (!full || pop);
  assign ovr_n      = push && full && !pop;
  assign rx_data    = rx_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_n;
      overrun   <= ovr_n;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: serial frames driven bit by bit, results
// compared against a queue-level model of what the receiver should deliver.
module tb_uart_rx_fifo;
  localparam int CLK_HZ = 16000000;
  localparam int BAUD   = 1000000;
  localparam int CPB    = 16;
  localparam int DEPTH  = 4;

  logic       clk = 1'b0, rst = 1'b1, uart_rxd = 1'b1, rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;
  logic [2:0] fifo_count;

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [7:0] got[$];
  int pop_cyc[$];
  int ferr_cnt = 0, ovr_cnt = 0, both_cnt = 0, valid_cycles = 0, first_valid = -1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) begin
        got.push_back(rx_data);
        pop_cyc.push_back(cyc);
      end
      if (rx_valid) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (frame_err && overrun) both_cnt++;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got.delete();
    pop_cyc.delete();
    ferr_cnt = 0; ovr_cnt = 0; valid_cycles = 0; first_valid = -1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len);
    @(posedge clk); #1;
    uart_rxd = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      hold(CPB);
    end
    uart_rxd = stop_v;
    hold(stop_len);
    uart_rxd = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hold(3);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", frame_err, overrun); end
    rst = 1'b0;
    hold(5);
  endtask

  task automatic test_single();
    logic [7:0] exp_q[$];
    int c0;
    logic [7:0] b;
    clear_mon();
    c0 = cyc + 1;
    send_frame(8'hA5, 1'b1, CPB);
    hold(20);
    checks++; if (got.size() != 1 || got[0] !== 8'hA5) begin errors++; $display("FAIL single_data got_n=%0d got=%h exp=a5", got.size(), got.size() ? got[0] : 8'hxx); end
    checks++; if (valid_cycles != 1) begin errors++; $display("FAIL single_valid_len got=%0d exp=1", valid_cycles); end
    checks++; if (first_valid - c0 != 2 + 9 * CPB + CPB / 2 + 1) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", first_valid - c0, 2 + 9 * CPB + CPB / 2 + 1); end
    checks++; if (fifo_count !== 3'd0 || ferr_cnt != 0 || ovr_cnt != 0) begin errors++; $display("FAIL single_idle count=%0d ferr=%0d ovr=%0d exp=0/0/0", fifo_count, ferr_cnt, ovr_cnt); end
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1, CPB);
    end
    hold(20);
    checks++; if (got != exp_q) begin errors++; $display("FAIL single_rand got_n=%0d exp_n=%0d", got.size(), exp_q.size()); end
  endtask

  task automatic test_glitch();
    clear_mon();
    uart_rxd = 1'b0;
    hold(5);
    uart_rxd = 1'b1;
    hold(30);
    checks++; if (got.size() != 0 || ferr_cnt != 0 || ovr_cnt != 0) begin errors++; $display("FAIL glitch_quiet pops=%0d ferr=%0d ovr=%0d exp=0/0/0", got.size(), ferr_cnt, ovr_cnt); end
    send_frame(8'h3C, 1'b1, CPB);
    hold(20);
    checks++; if (got.size() != 1 || got[0] !== 8'h3C) begin errors++; $display("FAIL glitch_next got_n=%0d got=%h exp=3c", got.size(), got.size() ? got[0] : 8'hxx); end
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_frame(8'h55, 1'b0, CPB + 40);
    hold(40);
    send_frame(8'h12, 1'b1, CPB);
    hold(20);
    checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL ferr_pulses got=%0d exp=1", ferr_cnt); end
    checks++; if (got.size() != 1 || got[0] !== 8'h12) begin errors++; $display("FAIL ferr_next got_n=%0d got=%h exp=12", got.size(), got.size() ? got[0] : 8'hxx); end
    checks++; if (ovr_cnt != 0) begin errors++; $display("FAIL ferr_no_ovr got=%0d exp=0", ovr_cnt); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp_q[$];
    rx_ready = 1'b0;
    clear_mon();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, CPB);
      if (exp_q.size() < DEPTH) exp_q.push_back(8'(i));
    end
    hold(20);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovr_count got=%0d exp=4", fifo_count); end
    checks++; if (ovr_cnt != 1) begin errors++; $display("FAIL ovr_pulses got=%0d exp=1", ovr_cnt); end
    rx_ready = 1'b1;
    hold(10);
    checks++; if (got != exp_q) begin errors++; $display("FAIL ovr_drain got_n=%0d exp_n=%0d", got.size(), exp_q.size()); end
    checks++; if (pop_cyc.size() != 4 || pop_cyc[3] - pop_cyc[0] != 3) begin errors++; $display("FAIL ovr_consecutive pops=%0d span=%0d exp=4/3", pop_cyc.size(), pop_cyc.size() ? pop_cyc[pop_cyc.size()-1] - pop_cyc[0] : -1); end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_q[$];
    rx_ready = 1'b0;
    clear_mon();
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, CPB);
    fork
      send_frame(8'h14, 1'b1, CPB);
      begin
        @(posedge clk);
        repeat (2 + 9 * CPB + CPB / 2 - 1) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    hold(20);
    checks++; if (fifo_count !== 3'd4 || ovr_cnt != 0) begin errors++; $display("FAIL fullpop_state count=%0d ovr=%0d exp=4/0", fifo_count, ovr_cnt); end
    checks++; if (got.size() != 1 || got[0] !== 8'h10) begin errors++; $display("FAIL fullpop_head got_n=%0d got=%h exp=10", got.size(), got.size() ? got[0] : 8'hxx); end
    rx_ready = 1'b1;
    hold(10);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h10 + 8'(i));
    checks++; if (got != exp_q) begin errors++; $display("FAIL fullpop_drain got_n=%0d exp_n=5", got.size()); end
  endtask

  task automatic test_reset_mid();
    rx_ready = 1'b0;
    clear_mon();
    send_frame(8'h21, 1'b1, CPB);
    send_frame(8'h42, 1'b1, CPB);
    fork
      send_frame(8'h77, 1'b1, CPB);
      begin
        @(posedge clk);
        repeat (5 * CPB + 5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00 || fifo_count !== 3'd0) begin errors++; $display("FAIL midrst_outs valid=%b data=%h count=%0d exp=0/00/0", rx_valid, rx_data, fifo_count); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL midrst_pulses got=%b%b exp=00", frame_err, overrun); end
        rst = 1'b0;
      end
    join
    hold(200);
    rx_ready = 1'b1;
    hold(10);
    // Bit 7 of 0x77 is 0 and may be framed as a start bit, yielding 0xFF.
    checks++; if (got.size() > 1 || (got.size() == 1 && got[0] !== 8'hFF) || ferr_cnt != 0) begin errors++; $display("FAIL midrst_leftover got_n=%0d ferr=%0d exp<=1 byte ff", got.size(), ferr_cnt); end
    clear_mon();
    send_frame(8'h88, 1'b1, CPB);
    hold(20);
    checks++; if (got.size() != 1 || got[0] !== 8'h88 || ovr_cnt != 0) begin errors++; $display("FAIL midrst_clean got_n=%0d got=%h exp=88", got.size(), got.size() ? got[0] : 8'hxx); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int exp_ferr = 0;
    logic [7:0] b;
    rx_ready = 1'b1;
    clear_mon();
    for (int i = 0; i < 14; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        exp_q.push_back(b);
        send_frame(b, 1'b1, CPB);
      end else begin
        exp_ferr++;
        send_frame(b, 1'b0, CPB + int'($urandom_range(0, 30)));
      end
      hold(int'($urandom_range(1, 20)));
    end
    hold(20);
    checks++; if (got != exp_q) begin errors++; $display("FAIL random_data got_n=%0d exp_n=%0d", got.size(), exp_q.size()); end
    checks++; if (ferr_cnt != exp_ferr || ovr_cnt != 0) begin errors++; $display("FAIL random_errs ferr=%0d ovr=%0d exp=%0d/0", ferr_cnt, ovr_cnt, exp_ferr); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    int exp_ovr, k;
    logic [7:0] b;
    for (int r = 0; r < 3; r++) begin
      rx_ready = 1'b0;
      clear_mon();
      exp_q.delete();
      exp_ovr = 0;
      k = int'($urandom_range(1, 7));
      for (int i = 0; i < k; i++) begin
        b = 8'($urandom);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovr++;
        send_frame(b, 1'b1, CPB);
      end
      hold(20);
      checks++; if (fifo_count !== 3'(exp_q.size()) || ovr_cnt != exp_ovr) begin errors++; $display("FAIL b2b_fill round=%0d count=%0d ovr=%0d exp=%0d/%0d", r, fifo_count, ovr_cnt, exp_q.size(), exp_ovr); end
      rx_ready = 1'b1;
      hold(10);
      checks++; if (got != exp_q) begin errors++; $display("FAIL b2b_drain round=%0d got_n=%0d exp_n=%0d", r, got.size(), exp_q.size()); end
    end
  endtask

  task automatic test_exclusive();
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL exclusive_pulses got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_full_pop();
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- 8N1 UART receiver with a small elastic FIFO.
- Sits directly downstream of the `uart_rxd` top-level pin. Presents received bytes to the CPU console/IO port through a valid/ready handshake.
- Detects false starts, framing errors and FIFO overruns. Reports each error as a single-cycle pulse.

Parameters:
- CLK_HZ, 16000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_BIT, (CLK_HZ+BAUD/2)/BAUD, derived local value, must be ≥8; elaboration error otherwise.
- FIFO_DEPTH, 4, byte slots, power of two, ≥2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- uart_rxd  input  1  asynchronous serial line, idle high.
- rx_data  output  8  byte at FIFO head; valid only while rx_valid=1.
- rx_valid  output  1  FIFO non-empty.
- rx_ready  input  1  consumer accepts head byte when rx_valid&rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: good byte dropped, FIFO full.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently held.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE; bit counter and baud counter clear; FIFO empties.
  - Outputs: rx_valid=0, rx_data=0, fifo_count=0, frame_err=0, overrun=0.
  - Synchronizer flops load 1.
  - Reset mid-frame aborts the frame with no push and no error pulse.
- Input: 2-flop synchronizer on uart_rxd, giving rxd_s. Adds 2 cycles of fixed latency.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rxd_s=0 → START, baud counter=0.
  - START: at count CLKS_PER_BIT/2-1, sample rxd_s.
    - rxd_s=1 → IDLE (false start, no pulse).
    - rxd_s=0 → DATA, counter=0, bit index=0.
  - DATA: at count CLKS_PER_BIT-1, shift rxd_s into the shift register LSB-first and restart the counter. After bit index 7 → STOP.
  - STOP: at count CLKS_PER_BIT-1, sample rxd_s.
    - rxd_s=1: push the byte → IDLE.
    - rxd_s=0: frame_err=1 for one cycle, byte discarded → BREAK.
  - BREAK: wait for rxd_s=1, then → IDLE. Holding the line low produces exactly one frame_err.
- Push timing: the byte is written on the stop-sample edge. rx_valid rises the next cycle if the FIFO was empty. Pin-to-valid ≈ 2 + 9.5·CLKS_PER_BIT + 1 cycles.
- FIFO:
  - Registered read/write pointers of width $clog2(FIFO_DEPTH) that wrap naturally, plus a count register.
  - rx_data is the registered head entry, combinational from storage.
  - Pop when rx_valid&rx_ready.
  - Push when full and no pop: byte dropped, overrun=1 for one cycle, contents unchanged.
  - Push and pop in the same cycle when full: both succeed, count unchanged, no overrun.
  - Push and pop in the same cycle when count=1: the head advances to the new byte, rx_valid stays 1.
  - Pop when empty is ignored.
- The receiver keeps sampling regardless of FIFO state. Back-pressure never stalls the line.
- frame_err and overrun are never both asserted in the same cycle, because a byte is either good or bad.

Test Plan (CLK_HZ=16000000, BAUD=1000000, CLKS_PER_BIT=16, FIFO_DEPTH=4, rx_ready=1 unless noted):
1. Send 0xA5 8N1 → rx_data=0xA5, rx_valid=1 for exactly 1 cycle, fifo_count returns to 0; no frame_err or overrun.
2. Glitch: uart_rxd low for 5 cycles then high → FSM returns to IDLE, no push, no pulses. A following 0x3C frame is received correctly.
3. Frame 0x55 with the stop bit held low, line low a further 40 cycles, then high, then 0x12 → one frame_err pulse, no push for 0x55; 0x12 received.
4. rx_ready=0, send 0x01..0x05 → fifo_count=4 and overrun pulses once on the 5th stop sample. Then rx_ready=1 → pops 0x01,0x02,0x03,0x04 in order on consecutive cycles.
5. FIFO full (0x10..0x13), rx_ready pulsed exactly on the stop-sample cycle of 0x14 → no overrun, count stays 4. Drain yields 0x11,0x12,0x13,0x14.
6. Assert rst for 1 cycle during bit 4 of 0x77, with 2 bytes queued → all outputs zero next cycle. The remainder of the frame is not pushed, except that a data bit of 0 is taken as a start bit (framing-dependent). A clean 0x88 after idle is received.
